arbitrate: RTL and testbench
============================

ARBITRATE -- requirements
Module: arbitrate

Interface
REQ-001 Parameter ARGW, default 16, width of each requester's data word.
REQ-002 Parameter ARGN, default 4, number of requesters; legal range 2 or more.
REQ-003 Parameter BURST, default 4, maximum transfers per grant; legal range 1 or more.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 arg_stb  input  ARGN  per-requester strobe; bit n means requester n holds valid data.
REQ-007 arg_dat  input  ARGN*ARGW  requester data; requester n occupies bits [ARGW*n +: ARGW].
REQ-008 arg_rdy  output  ARGN  per-requester ready; at most one bit is set in any cycle.
REQ-009 res_stb  output  1  result valid.
REQ-010 res_dat  output  $clog2(ARGN)+ARGW  result word, {source index, data}.
REQ-011 res_rdy  input  1  downstream ready.

Function
REQ-012 A transfer on requester n (acceptance) occurs in a cycle where arg_stb[n] and arg_rdy[n] are both 1; a result acknowledge occurs in a cycle where res_stb and res_rdy are both 1.
REQ-013 The FSM has two states:
- IDLE: no grant held; arg_rdy is 0.
- GRANT: one requester, gnt, holds the grant.
REQ-014 Rotation pointer ptr, range 0..ARGN-1: in IDLE with any arg_stb bit set, the controller SHALL pick the first set bit, searching circularly from ptr upward, load that index into gnt, clear burst counter cnt to 0, and enter GRANT on the next edge.
REQ-015 In IDLE with arg_stb all zero, the state and ptr SHALL remain unchanged.
REQ-016 In GRANT, arg_rdy[gnt] SHALL be 1 exactly when arg_stb[gnt] is 1 and the output register is free (res_stb is 0 or res_rdy is 1); all other arg_rdy bits SHALL be 0.
REQ-017 On acceptance, the next edge SHALL set res_stb to 1 and res_dat to {gnt, arg_dat[ARGW*gnt +: ARGW]}.
- Result latency is one cycle.
- Full throughput is achieved while res_rdy stays 1.
REQ-018 On a result acknowledge with no acceptance in the same cycle, res_stb SHALL clear on the next edge.
REQ-019 While res_stb is 1 and res_rdy is 0, res_dat SHALL hold stable.
REQ-020 Each acceptance in GRANT SHALL increment cnt.
REQ-021 An acceptance with cnt equal to BURST-1 SHALL release the grant.
REQ-022 In GRANT, a cycle with arg_stb[gnt] equal to 0 SHALL release the grant without a transfer, even when cnt is 0.
REQ-023 On release, ptr SHALL be set to (gnt+1) mod ARGN and the state SHALL return to IDLE.
- This gives exactly one bubble cycle before the next grant.
- The wrap from ARGN-1 to 0 is required.
REQ-024 With BURST equal to 1, behaviour SHALL reduce to plain round-robin, one transfer per grant.
REQ-025 Requests on non-granted inputs arriving mid-grant SHALL NOT alter gnt, cnt or ptr.
REQ-026 Under continuous requests on all inputs, every requester SHALL be granted within ARGN grants (starvation-free).

Reset
REQ-027 While rst is 1, at the clock edge the following SHALL be set: state IDLE, ptr 0, gnt 0, cnt 0, res_stb 0, res_dat 0.
REQ-028 arg_rdy SHALL be 0 in the first cycle after reset.
REQ-029 Reset asserted mid-burst or with res_stb 1 SHALL discard the pending result and the grant, with no acknowledge required.

Structure
REQ-030 The FSM state encodings SHALL be module-local constants; no shared package is required.
REQ-031 One combinational sub-module, rotate_pick, SHALL implement the circular priority search.
- Parameter: ARGN.
- Inputs: request vector, start index.
- Outputs: found flag, selected index.

Verification
REQ-032 Reset then arg_stb=0010, res_rdy=1, ARGN=4, BURST=4, 4 words -> GRANT to 1 after one cycle; results {1,d0}..{1,d3} on 4 consecutive cycles; then release, ptr=2.
REQ-033 arg_stb=1111 held, BURST=1, res_rdy=1 -> result tags 0,1,2,3,0 in order, with one bubble cycle between results; wrap from 3 to 0 verified.
REQ-034 Grant to requester 2, res_rdy=0 for 3 cycles after the first acceptance -> arg_rdy=0, res_stb=1 and res_dat stable; resumes when res_rdy=1, with no data lost or duplicated.
REQ-035 Grant to requester 0, which drops arg_stb after 2 transfers with BURST=4 -> release with cnt=2, ptr=1; the next grant goes to the lowest pending index at or above 1.
REQ-036 rst asserted mid-burst with res_stb=1 -> next cycle res_stb=0, arg_rdy=0, ptr=0; after rst falls, arbitration restarts from requester 0.

Source files
------------

// File: rtl/rotate_pick.sv
// Circular priority search: first set request bit at or above start_i, wrapping.
module rotate_pick #(
  parameter  int ARGN = 4,
  localparam int IW   = $clog2(ARGN)
) (
  input  logic [ARGN-1:0] req_i,
  input  logic [IW-1:0]   start_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);

  int cand;

  // Walk from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int i = ARGN - 1; i >= 0; i--) begin
      cand = (int'(start_i) + i) % ARGN;
      if (req_i[IW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/arbitrate.sv
// Round-robin burst arbiter: one requester holds the grant for up to BURST
// transfers into a single registered result slot tagged with the source index.
module arbitrate #(
  parameter int ARGW  = 16,
  parameter int ARGN  = 4,
  parameter int BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ARGN-1:0]               arg_stb,
  input  logic [ARGN*ARGW-1:0]          arg_dat,
  output logic [ARGN-1:0]               arg_rdy,
  output logic                          res_stb,
  output logic [$clog2(ARGN)+ARGW-1:0]  res_dat,
  input  logic                          res_rdy
);

  localparam int IW = $clog2(ARGN);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                res_stb_q, res_stb_d;
  logic [IW+ARGW-1:0]  res_dat_q, res_dat_d;

  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                out_free;
  logic                accept;
  logic                release_gnt;

  rotate_pick #(.ARGN(ARGN)) u_pick (
    .req_i   (arg_stb),
    .start_i (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    res_stb_d   = res_stb_q;
    res_dat_d   = res_dat_q;
    arg_rdy     = '0;
    accept      = 1'b0;
    release_gnt = 1'b0;
    out_free    = !res_stb_q || res_rdy;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!arg_stb[gnt_q]) begin
          release_gnt = 1'b1;
        end else if (out_free) begin
          arg_rdy[gnt_q] = 1'b1;
          accept         = 1'b1;
          if (cnt_q == CW'(BURST - 1)) release_gnt = 1'b1;
          else                         cnt_d       = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Moving the pointer past the released requester is what gives fairness.
    if (release_gnt) begin
      state_d = IDLE;
      ptr_d   = (gnt_q == IW'(ARGN - 1)) ? '0 : gnt_q + 1'b1;
    end

    if (accept) begin
      res_stb_d = 1'b1;
      res_dat_d = {gnt_q, arg_dat[ARGW*gnt_q +: ARGW]};
    end else if (res_rdy) begin
      res_stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      res_stb_q <= res_stb_d;
      res_dat_q <= res_dat_d;
    end
  end

  assign res_stb = res_stb_q;
  assign res_dat = res_dat_q;

endmodule

// File: tb/tb_arbitrate.sv
// Cycle-table bench for arbitrate: per-cycle ready/valid expectations plus a
// scoreboard of accepted words checked against the tagged results.
module tb_arbitrate;

  localparam int ARGW = 16;
  localparam int ARGN = 4;
  localparam int RW   = 2 + ARGW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [ARGN-1:0]      arg_stb = '0;
  logic [ARGN*ARGW-1:0] arg_dat = '0;
  logic                 res_rdy = 1'b1;

  logic [ARGN-1:0]      rdy_a, rdy_b;
  logic                 stb_a, stb_b;
  logic [RW-1:0]        dat_a, dat_b;

  always #5 clk = ~clk;

  arbitrate #(.ARGW(ARGW), .ARGN(ARGN), .BURST(4)) dut_a (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat),
    .arg_rdy(rdy_a), .res_stb(stb_a), .res_dat(dat_a), .res_rdy(res_rdy)
  );

  arbitrate #(.ARGW(ARGW), .ARGN(ARGN), .BURST(1)) dut_b (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat),
    .arg_rdy(rdy_b), .res_stb(stb_b), .res_dat(dat_b), .res_rdy(res_rdy)
  );

  typedef struct {
    bit         b1;
    bit         rst;
    logic [3:0] stb;
    bit         rdy;
    logic [3:0] exp_rdy;
    bit         exp_stb;
  } vec_t;

  vec_t          tbl[$];
  logic [RW-1:0] sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cur    = 0;

  task automatic add(input bit b1, input bit r, input logic [3:0] s, input bit rd,
                     input logic [3:0] er, input bit es);
    vec_t v;
    v.b1 = b1; v.rst = r; v.stb = s; v.rdy = rd; v.exp_rdy = er; v.exp_stb = es;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, cur, act, req);
    end
  endtask

  function automatic logic [ARGW-1:0] lane_word(input int n, input int k);
    return {4'(n), 12'(k)};
  endfunction

  initial begin
    logic [3:0]    a_rdy;
    logic          a_stb;
    logic [RW-1:0] a_dat;

    // Four-word burst from requester 1, pointer advance, wrap 3->0.
    add(0,1,4'b0000,1,4'b0000,0);
    add(0,0,4'b0010,1,4'b0000,0);
    add(0,0,4'b0010,1,4'b0010,0);
    add(0,0,4'b0010,1,4'b0010,1);
    add(0,0,4'b0010,1,4'b0010,1);
    add(0,0,4'b0010,1,4'b0010,1);
    add(0,0,4'b1010,1,4'b0000,1);
    add(0,0,4'b1010,1,4'b1000,0);
    add(0,0,4'b0010,1,4'b0000,1);
    add(0,0,4'b0011,1,4'b0000,0);
    add(0,0,4'b0011,1,4'b0001,0);
    add(0,0,4'b0000,1,4'b0000,1);
    add(0,0,4'b0000,1,4'b0000,0);
    // Backpressure on requester 2 for three cycles.
    add(0,1,4'b0000,1,4'b0000,0);
    add(0,0,4'b0100,1,4'b0000,0);
    add(0,0,4'b0100,1,4'b0100,0);
    add(0,0,4'b0100,0,4'b0000,1);
    add(0,0,4'b0100,0,4'b0000,1);
    add(0,0,4'b0100,0,4'b0000,1);
    add(0,0,4'b0100,1,4'b0100,1);
    add(0,0,4'b0100,1,4'b0100,1);
    add(0,0,4'b0100,1,4'b0100,1);
    add(0,0,4'b0000,1,4'b0000,1);
    add(0,0,4'b0000,1,4'b0000,0);
    // Requester 0 drops after two transfers; others were waiting.
    add(0,1,4'b0000,1,4'b0000,0);
    add(0,0,4'b0001,1,4'b0000,0);
    add(0,0,4'b0001,1,4'b0001,0);
    add(0,0,4'b0001,1,4'b0001,1);
    add(0,0,4'b1100,1,4'b0000,1);
    add(0,0,4'b1100,1,4'b0000,0);
    add(0,0,4'b1100,1,4'b0100,0);
    add(0,0,4'b0000,1,4'b0000,1);
    add(0,0,4'b0000,1,4'b0000,0);
    // Reset mid-burst with a pending result, then empty grant at cnt 0.
    add(0,1,4'b0000,1,4'b0000,0);
    add(0,0,4'b0010,1,4'b0000,0);
    add(0,0,4'b0010,1,4'b0010,0);
    add(0,0,4'b0010,0,4'b0000,1);
    add(0,1,4'b0010,0,4'b0000,0);
    add(0,0,4'b0110,1,4'b0000,0);
    add(0,0,4'b0110,1,4'b0010,0);
    add(0,0,4'b0000,1,4'b0000,1);
    add(0,0,4'b0000,1,4'b0000,0);
    add(0,0,4'b0001,1,4'b0000,0);
    add(0,0,4'b0000,1,4'b0000,0);
    add(0,0,4'b0011,1,4'b0000,0);
    add(0,0,4'b0011,1,4'b0010,0);
    add(0,0,4'b0000,1,4'b0000,1);
    add(0,0,4'b0000,1,4'b0000,0);
    // BURST=1 plain round-robin with all requesters active.
    add(1,1,4'b0000,1,4'b0000,0);
    add(1,0,4'b1111,1,4'b0000,0);
    add(1,0,4'b1111,1,4'b0001,0);
    add(1,0,4'b1111,1,4'b0000,1);
    add(1,0,4'b1111,1,4'b0010,0);
    add(1,0,4'b1111,1,4'b0000,1);
    add(1,0,4'b1111,1,4'b0100,0);
    add(1,0,4'b1111,1,4'b0000,1);
    add(1,0,4'b1111,1,4'b1000,0);
    add(1,0,4'b1111,1,4'b0000,1);
    add(1,0,4'b1111,1,4'b0001,0);
    add(1,0,4'b0000,1,4'b0000,1);
    add(1,0,4'b0000,1,4'b0000,0);

    for (int i = 0; i < tbl.size(); i++) begin
      cur = i;
      @(posedge clk);
      #1;
      rst     = tbl[i].rst;
      arg_stb = tbl[i].stb;
      res_rdy = tbl[i].rdy;
      for (int n = 0; n < ARGN; n++) arg_dat[ARGW*n +: ARGW] = lane_word(n, i);
      @(negedge clk);
      if (tbl[i].rst) begin
        sb_q.delete();
      end else begin
        a_rdy = tbl[i].b1 ? rdy_b : rdy_a;
        a_stb = tbl[i].b1 ? stb_b : stb_a;
        a_dat = tbl[i].b1 ? dat_b : dat_a;
        chk("arg_rdy", 32'(a_rdy), 32'(tbl[i].exp_rdy));
        chk("res_stb", 32'(a_stb), 32'(tbl[i].exp_stb));
        if (a_stb) begin
          if (sb_q.size() == 0) begin
            chk("res_unexpected", 32'(a_dat), 32'hFFFF_FFFF);
          end else begin
            chk("res_dat", 32'(a_dat), 32'(sb_q[0]));
            if (tbl[i].rdy) begin
              $display("vec %0d: result tag=%0d data=%h", i, a_dat[RW-1 -: 2], a_dat[ARGW-1:0]);
              void'(sb_q.pop_front());
            end
          end
        end
        for (int n = 0; n < ARGN; n++)
          if (tbl[i].exp_rdy[n] && tbl[i].stb[n])
            sb_q.push_back({2'(n), lane_word(n, i)});
      end
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
